// File: rtl/banco_registradores_pkg.sv
// Shared constants and types for the register file / ALU write-back slice.
package banco_registradores_pkg;

    localparam int LARGURA  = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // One in-flight ALU op waiting for its result to come back.
    typedef struct packed {
        logic              pendente;
        logic [ADDR_W-1:0] rd_pend;
        logic              hilo_pend;
    } pend_t;

endpackage

// File: rtl/banco_registradores_memoria.sv
// memoria_registradores: flop array, two async reads, ALU and external write ports.
// The ALU write port always wins over the external port on an address collision.
module memoria_registradores
    import banco_registradores_pkg::*;
#(
    parameter int LARGURA  = banco_registradores_pkg::LARGURA,
    parameter int NUM_REGS = banco_registradores_pkg::NUM_REGS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  addr_a,
    input  logic [ADDR_W-1:0]  addr_b,
    output logic [LARGURA-1:0] data_a,
    output logic [LARGURA-1:0] data_b,
    input  logic               we_alu,
    input  logic [ADDR_W-1:0]  addr_alu,
    input  logic [LARGURA-1:0] data_alu,
    input  logic               we_ext,
    input  logic [ADDR_W-1:0]  addr_ext,
    input  logic [LARGURA-1:0] data_ext
);

    logic [LARGURA-1:0] mem [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            mem[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (we_alu && addr_alu == ADDR_W'(i)) begin
                    mem[i] <= data_alu;
                end else if (we_ext && addr_ext == ADDR_W'(i)) begin
                    mem[i] <= data_ext;
                end
            end
        end
    end

    assign data_a = (addr_a == REG_ZERO) ? '0 : mem[addr_a];
    assign data_b = (addr_b == REG_ZERO) ? '0 : mem[addr_b];

endmodule

// File: rtl/banco_registradores.sv
// Register file plus one-stage ALU write-back and HI/LO pair.
// Define BANCO_BYPASS_EN to forward saidaULA to pending reads instead of flagging conflito.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int LARGURA  = banco_registradores_pkg::LARGURA,
    parameter int NUM_REGS = banco_registradores_pkg::NUM_REGS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  enderecoRS,
    input  logic [ADDR_W-1:0]  enderecoRT,
    output logic [LARGURA-1:0] RS,
    output logic [LARGURA-1:0] RT,
    input  logic               emiteOP,
    input  logic [ADDR_W-1:0]  enderecoRD,
    input  logic               escreveHILO,
    input  logic [LARGURA-1:0] saidaULA,
    input  logic [LARGURA-1:0] saidaHI,
    input  logic [LARGURA-1:0] saidaLO,
    input  logic               escreveExt,
    input  logic [ADDR_W-1:0]  enderecoExt,
    input  logic [LARGURA-1:0] dadoExt,
    output logic [LARGURA-1:0] HI,
    output logic [LARGURA-1:0] LO,
    output logic               conflito
);

    pend_t              pend;
    logic               wb_en;
    logic               hit_rs;
    logic               hit_rt;
    logic [LARGURA-1:0] rs_raw;
    logic [LARGURA-1:0] rt_raw;

    always_ff @(posedge clock) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend.pendente  <= emiteOP;
            pend.rd_pend   <= enderecoRD;
            pend.hilo_pend <= escreveHILO;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (pend.pendente && pend.hilo_pend) begin
            HI <= saidaHI;
            LO <= saidaLO;
        end
    end

    // Writes to r0 are dropped here so they never block an external write.
    assign wb_en  = pend.pendente && (pend.rd_pend != REG_ZERO);
    assign hit_rs = wb_en && (enderecoRS == pend.rd_pend);
    assign hit_rt = wb_en && (enderecoRT == pend.rd_pend);

    memoria_registradores #(
        .LARGURA  (LARGURA),
        .NUM_REGS (NUM_REGS)
    ) u_memoria (
        .clock    (clock),
        .reset    (reset),
        .addr_a   (enderecoRS),
        .addr_b   (enderecoRT),
        .data_a   (rs_raw),
        .data_b   (rt_raw),
        .we_alu   (wb_en),
        .addr_alu (pend.rd_pend),
        .data_alu (saidaULA),
        .we_ext   (escreveExt),
        .addr_ext (enderecoExt),
        .data_ext (dadoExt)
    );

`ifdef BANCO_BYPASS_EN
    always_comb begin
        RS       = hit_rs ? saidaULA : rs_raw;
        RT       = hit_rt ? saidaULA : rt_raw;
        conflito = 1'b0;
    end
`else
    always_comb begin
        RS       = rs_raw;
        RT       = rt_raw;
        conflito = hit_rs || hit_rt;
    end
`endif

endmodule

// File: doc/banco_registradores.md
# banco_registradores

Register file and write-back stage around the processor's ALU. Provides the two combinational operand reads that drive the ALU's `RS`/`RT` inputs. Tracks the one-cycle latency of the clocked ALU and writes `saidaULA` back to the destination register one cycle after issue. Also holds the architectural HI/LO pair fed by the ALU's multiply outputs.

## Interface
Parameters:
- `LARGURA`, 32, data width of every register.
- `NUM_REGS`, 32, register count; addresses are 5 bits, register 0 reads as zero.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enderecoRS` in 5: read address A.
- `enderecoRT` in 5: read address B.
- `RS` out 32: combinational read of A, feeds the ALU.
- `RT` out 32: combinational read of B, feeds the ALU.
- `emiteOP` in 1: an ALU op is issued this cycle (the ALU samples `RS`/`RT` at this edge).
- `enderecoRD` in 5: destination of the issued op.
- `escreveHILO` in 1: the issued op also updates HI/LO.
- `saidaULA` in 32: ALU result, valid the cycle after issue.
- `saidaHI` in 32: ALU high word, valid the cycle after issue.
- `saidaLO` in 32: ALU low word, valid the cycle after issue.
- `escreveExt` in 1: external write port enable (loads and immediates).
- `enderecoExt` in 5: external write address.
- `dadoExt` in 32: external write data.
- `HI` out 32: architectural HI register.
- `LO` out 32: architectural LO register.
- `conflito` out 1: read hazard on a pending write-back (combinational).

## Operation
- Storage: `NUM_REGS`×`LARGURA` flops. Register 0 ignores all writes and always reads 0.
- Issue pipeline, one stage: on an edge with `emiteOP=1`, latch `pendente=1`, `rdPend=enderecoRD` and `hiloPend=escreveHILO`. Otherwise clear `pendente`.
- Write-back: on the edge after issue (`pendente=1`), write `saidaULA` to `reg[rdPend]` if `rdPend≠0`. If `hiloPend=1`, also write `HI<=saidaHI` and `LO<=saidaLO`.
- Back-to-back issue every cycle is legal. The write-back for op N and the latch for op N+1 occur on the same edge.
- External port: `escreveExt=1` writes `dadoExt` to `reg[enderecoExt]` on the edge. On the same edge the ALU write-back may also write.
  - Different addresses: both writes happen.
  - Same address: the ALU write-back wins and the external write is dropped.
- `conflito=1` when `pendente=1`, `rdPend≠0`, and (`enderecoRS==rdPend` or `enderecoRT==rdPend`). It is forced to 0 when BYPASS is compiled in.
- No forwarding of same-edge external writes. A read in the same cycle as an external write returns the old value.
- Reset: all registers 0, `HI=LO=0`, `pendente=0`, `conflito=0`. `RS`/`RT` read 0.
- Reset mid-operation: any pending write-back is discarded, and the `saidaULA` of that cycle is not written.

## Timing
- Read latency: 0 cycles (combinational from address to `RS`/`RT`).
- Issue at cycle N: the ALU samples operands at the end of N, `saidaULA` is valid during N+1, and the register is updated at the end of N+1. The new value is readable from the register array in N+2.
- HI/LO follow the same timing; they are visible at the outputs in N+2.
- `conflito` asserts only during N+1 when a read address matches the pending destination. The controller must stall issue while it is high.

## Configuration
- `BANCO_BYPASS_EN`
  - Defined: during N+1, a read of `rdPend` (≠0) returns `saidaULA` directly, and `conflito` is tied to 0.
  - Undefined: no forwarding; `conflito` behaves as specified in Operation.

## Structure
- Shared package holds:
  - `LARGURA` and `NUM_REGS`.
  - Address width 5.
  - Constant `REG_ZERO=5'd0`.
  - A record type for the pending write-back (`pendente`, `rdPend`, `hiloPend`).
- One sub-module, `memoria_registradores`: the flop array with 2 async read ports, 2 write ports, fixed ALU-over-external priority, and register-0 masking.
- The top level holds the issue pipeline, HI/LO, bypass mux, and hazard logic.

## Test plan
- Reset: after `reset=1` for 2 cycles → `RS=RT=HI=LO=0`, `conflito=0` for all addresses.
- External write: `escreveExt=1`, `enderecoExt=5`, `dadoExt=0x00001234`; next cycle `enderecoRS=5` → `RS=0x00001234`. Writing r0 with 0xFFFFFFFF → r0 still reads 0.
- Issue and write-back: issue with `enderecoRD=3`, then drive `saidaULA=0x0000000A` the next cycle.
  - With BYPASS: `enderecoRT=3` during N+1 → `RT=0x0000000A`, `conflito=0`.
  - Without BYPASS: `conflito=1`, and in N+2 `RT=0x0000000A`.
- Collision: ALU write-back to r7 = 0x11111111 and external write r7 = 0x22222222 on the same edge → r7 reads 0x11111111.
- Multiply to HI/LO: issue with `escreveHILO=1`, then `saidaHI=0x00000001`, `saidaLO=0x80000000` → `HI=0x00000001`, `LO=0x80000000` in N+2. An issue with `escreveHILO=0` leaves them unchanged.
- Reset mid-op: issue with `enderecoRD=4`, then assert `reset` in N+1 with `saidaULA=0xDEADBEEF` → r4 reads 0 and `conflito=0` after reset.
